bypass_regfile_sb: RTL and testbench

- Parametrised successor to the pipeline's register file.
- Provides DATA_W x 2^ADDR_W storage with NUM_RD asynchronous read ports and an optional hard-wired zero register.
- Supports same-cycle write-to-read bypass.
- Adds a pending-write scoreboard. Decode uses it to raise a load-use stall when a read address targets a register whose producing load has not yet written back.
- Sits between instruction fetch/decode (raddr) and the M-stage writeback (we/waddr/wdata).

---
 rtl/bypass_regfile_sb.sv | 118 +++++++++++
 tb/tb_bypass_regfile_sb.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bypass_regfile_sb.sv
// bypass_regfile_sb
// Register file with NUM_RD combinational read ports, optional hard-wired zero
// register, same-cycle write-to-read bypass, and a pending-load scoreboard that
// flags reads of registers whose producing load has not yet written back.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   we, waddr, wdata      writeback port
//   raddr, rd_en          packed read addresses; per-port "operand used" flag
//   rdata                 packed read data (port i at [i*DATA_W +: DATA_W])
//   pend_set, pend_addr   mark a load destination as pending
//   pend_flush            clear every pending bit
//   busy, stall           per-port pending hit; OR of busy & rd_en
//   pend_cnt              registered population count of pending bits
module bypass_regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    input  logic [NUM_RD-1:0]        rd_en,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    input  logic                     pend_set,
    input  logic [ADDR_W-1:0]        pend_addr,
    input  logic                     pend_flush,
    output logic [NUM_RD-1:0]        busy,
    output logic                     stall,
    output logic [ADDR_W:0]          pend_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic [ADDR_W:0]   pend_cnt_q, pend_cnt_d;

    logic write_ok;
    assign write_ok = we && !((ZERO_REG != 0) && (waddr == '0));

    always_comb begin
        regs_d = regs_q;
        if (write_ok) begin
            regs_d[waddr] = wdata;
        end
    end

    // Set is evaluated last so an issuing load wins over a flush or a retiring
    // writeback to the same register in the same cycle.
    always_comb begin
        pend_d     = pend_q;
        pend_cnt_d = '0;
        for (int a = 0; a < DEPTH; a++) begin
            if (pend_flush) begin
                pend_d[a] = 1'b0;
            end else if (we && (waddr == ADDR_W'(a))) begin
                pend_d[a] = 1'b0;
            end
            if (pend_set && (pend_addr == ADDR_W'(a))) begin
                pend_d[a] = 1'b1;
            end
        end
        if (ZERO_REG != 0) begin
            pend_d[0] = 1'b0;
        end
        for (int a = 0; a < DEPTH; a++) begin
            pend_cnt_d = pend_cnt_d + {{ADDR_W{1'b0}}, pend_d[a]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int a = 0; a < DEPTH; a++) begin
                regs_q[a] <= '0;
            end
            pend_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            pend_q     <= pend_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              byp;
        logic [DATA_W-1:0] rd;

        assign ra  = raddr[i*ADDR_W +: ADDR_W];
        assign byp = (BYPASS != 0) && we && (waddr == ra);

        always_comb begin
            if ((ZERO_REG != 0) && (ra == '0)) begin
                rd = '0;
            end else if (byp) begin
                rd = wdata;
            end else begin
                rd = regs_q[ra];
            end
        end

        assign rdata[i*DATA_W +: DATA_W] = rd;
        // A retiring writeback seen through the bypass already satisfies the read.
        assign busy[i] = pend_q[ra] & ~byp;
    end

    assign stall    = |(busy & rd_en);
    assign pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_bypass_regfile_sb.sv
// tb_bypass_regfile_sb
// Directed checks on a default-parameter instance (NUM_RD=2, ZERO_REG=1,
// BYPASS=1) followed by a randomised run of a NUM_RD=4, BYPASS=0, ZERO_REG=0
// instance against a behavioural reference model.
module tb_bypass_regfile_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default instance
    logic        reset, we, pend_set, pend_flush;
    logic [4:0]  waddr, pend_addr;
    logic [31:0] wdata;
    logic [9:0]  raddr;
    logic [1:0]  rd_en, busy;
    logic [63:0] rdata;
    logic        stall;
    logic [5:0]  pend_cnt;

    bypass_regfile_sb u_dut (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rd_en(rd_en), .rdata(rdata), .pend_set(pend_set),
        .pend_addr(pend_addr), .pend_flush(pend_flush), .busy(busy),
        .stall(stall), .pend_cnt(pend_cnt)
    );

    // four-port instance, no bypass, no zero register
    logic        r_reset, r_we, r_pend_set, r_pend_flush;
    logic [2:0]  r_waddr, r_pend_addr;
    logic [15:0] r_wdata;
    logic [11:0] r_raddr;
    logic [3:0]  r_rd_en, r_busy;
    logic [63:0] r_rdata;
    logic        r_stall;
    logic [3:0]  r_pend_cnt;

    bypass_regfile_sb #(
        .DATA_W(16), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(0), .BYPASS(0)
    ) u_dut4 (
        .clk(clk), .reset(r_reset), .we(r_we), .waddr(r_waddr), .wdata(r_wdata),
        .raddr(r_raddr), .rd_en(r_rd_en), .rdata(r_rdata), .pend_set(r_pend_set),
        .pend_addr(r_pend_addr), .pend_flush(r_pend_flush), .busy(r_busy),
        .stall(r_stall), .pend_cnt(r_pend_cnt)
    );

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    logic [15:0] m_regs [8];
    logic [7:0]  m_pend;
    logic [2:0]  ra;
    logic [63:0] exp_rd;
    logic [3:0]  exp_busy;
    int          cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 0; waddr = 0; wdata = 0; pend_set = 0; pend_addr = 0; pend_flush = 0;
    endtask

    initial begin
        reset = 1; idle(); raddr = 0; rd_en = 2'b11;
        r_reset = 1; r_we = 0; r_waddr = 0; r_wdata = 0; r_raddr = 0; r_rd_en = 0;
        r_pend_set = 0; r_pend_addr = 0; r_pend_flush = 0;
        tick();
        reset = 0;

        // reset state across every address
        for (int a = 0; a < 32; a++) begin
            raddr = {5'(a), 5'(a)};
            #1;
            chk("rst_rdata", rdata, 64'h0);
            chk("rst_busy", busy, 2'b00);
            chk("rst_stall", stall, 1'b0);
        end
        chk("rst_cnt", pend_cnt, 6'd0);

        // bypassed write
        we = 1; waddr = 5; wdata = 32'hDEADBEEF; raddr = {5'd6, 5'd5};
        #1;
        chk("byp_same_cycle", rdata, {32'h0, 32'hDEADBEEF});
        tick(); idle();
        #1;
        chk("byp_stored", rdata, {32'h0, 32'hDEADBEEF});

        // zero register
        we = 1; waddr = 0; wdata = 32'h1234; raddr = {5'd5, 5'd0};
        #1;
        chk("zero_byp", rdata, {32'hDEADBEEF, 32'h0});
        tick(); idle();
        #1;
        chk("zero_write", rdata, {32'hDEADBEEF, 32'h0});
        pend_set = 1; pend_addr = 0;
        tick(); idle();
        #1;
        chk("zero_pend_cnt", pend_cnt, 6'd0);
        chk("zero_busy", busy, 2'b00);

        // load-use stall
        pend_set = 1; pend_addr = 8; raddr = {5'd8, 5'd5}; rd_en = 2'b10;
        #1;
        chk("lu_latency", busy, 2'b00);
        tick(); idle();
        #1;
        chk("lu_busy", busy, 2'b10);
        chk("lu_stall", stall, 1'b1);
        chk("lu_cnt", pend_cnt, 6'd1);
        rd_en = 2'b00;
        #1;
        chk("lu_no_use", stall, 1'b0);
        rd_en = 2'b10; we = 1; waddr = 8; wdata = 32'h55;
        #1;
        chk("lu_wb_busy", busy, 2'b00);
        chk("lu_wb_stall", stall, 1'b0);
        chk("lu_wb_rdata", rdata, {32'h55, 32'hDEADBEEF});
        tick(); idle();
        #1;
        chk("lu_wb_cnt", pend_cnt, 6'd0);
        chk("lu_wb_stored", rdata, {32'h55, 32'hDEADBEEF});

        // flush together with set
        pend_set = 1; pend_addr = 3; tick();
        pend_addr = 4; tick();
        pend_addr = 9; tick(); idle();
        #1;
        chk("pend3_cnt", pend_cnt, 6'd3);
        pend_flush = 1; pend_set = 1; pend_addr = 3;
        tick(); idle();
        raddr = {5'd4, 5'd3};
        #1;
        chk("flush_set_cnt", pend_cnt, 6'd1);
        chk("flush_set_busy", busy, 2'b01);

        // retiring write together with set
        pend_set = 1; pend_addr = 7; tick(); idle();
        we = 1; waddr = 7; wdata = 32'h77; pend_set = 1; pend_addr = 7;
        raddr = {5'd3, 5'd7};
        #1;
        chk("retire_set_busy_now", busy, 2'b10);
        tick(); idle();
        #1;
        chk("retire_set_busy", busy, 2'b11);
        chk("retire_set_cnt", pend_cnt, 6'd2);
        chk("retire_set_rdata", rdata[31:0], 32'h77);

        // reset during a stall
        pend_set = 1; pend_addr = 12; tick(); idle();
        raddr = {5'd5, 5'd12}; rd_en = 2'b01;
        #1;
        chk("pre_rst_cnt", pend_cnt, 6'd3);
        chk("pre_rst_stall", stall, 1'b1);
        reset = 1; we = 1; waddr = 10; wdata = 32'hAAAA; pend_set = 1; pend_addr = 13;
        tick(); idle(); reset = 0;
        #1;
        chk("mid_rst_cnt", pend_cnt, 6'd0);
        chk("mid_rst_stall", stall, 1'b0);
        chk("mid_rst_busy", busy, 2'b00);
        chk("mid_rst_rdata", rdata, 64'h0);
        raddr = {5'd13, 5'd10};
        #1;
        chk("mid_rst_nowrite", rdata, 64'h0);
        chk("mid_rst_noset", busy, 2'b00);

        // randomised four-port run
        for (int a = 0; a < 8; a++) m_regs[a] = '0;
        m_pend = '0;
        for (int c = 0; c < 300; c++) begin
            r_reset      = ($urandom_range(0, 31) == 0);
            r_we         = 1'($urandom_range(0, 1));
            r_waddr      = 3'($urandom);
            r_wdata      = 16'($urandom);
            r_raddr      = 12'($urandom);
            r_rd_en      = 4'($urandom);
            r_pend_set   = 1'($urandom_range(0, 1));
            r_pend_addr  = 3'($urandom);
            r_pend_flush = ($urandom_range(0, 15) == 0);
            #1;
            exp_rd = '0; exp_busy = '0; cnt = 0;
            for (int p = 0; p < 4; p++) begin
                ra = r_raddr[p*3 +: 3];
                exp_rd[p*16 +: 16] = m_regs[ra];
                exp_busy[p] = m_pend[ra];
            end
            for (int a = 0; a < 8; a++) cnt += int'(m_pend[a]);
            chk("rnd_rdata", r_rdata, exp_rd);
            chk("rnd_busy", r_busy, exp_busy);
            chk("rnd_stall", r_stall, |(exp_busy & r_rd_en));
            chk("rnd_cnt", r_pend_cnt, 4'(cnt));
            if (r_reset) begin
                for (int a = 0; a < 8; a++) m_regs[a] = '0;
                m_pend = '0;
            end else begin
                if (r_we) m_regs[r_waddr] = r_wdata;
                for (int a = 0; a < 8; a++) begin
                    if (r_pend_flush) m_pend[a] = 1'b0;
                    else if (r_we && r_waddr == 3'(a)) m_pend[a] = 1'b0;
                    if (r_pend_set && r_pend_addr == 3'(a)) m_pend[a] = 1'b1;
                end
            end
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
